matched_filter_controller: RTL and testbench
============================================

// Module: matched_filter_controller
// PURPOSE
//  Sequences one matched-filter run: loads COEFF_LENGTH coefficients into the filter, streams DATA_LENGTH
//  input samples through it, then flushes COEFF_LENGTH-1 zero samples so the full convolution emerges.
//  Flags which filter output cycles are valid and signals run completion. Sits between the coefficient ROM,
//  the sample source and the matched_filter datapath, and replaces the free-running enable used today.
// PARAMETERS
//  COEFF_LENGTH     10000   number of filter coefficients (>=2)
//  DATA_LENGTH      330000  input samples per run (>=1)
//  COEFF_ADDR_WIDTH 14      width of coeffAddr; must hold COEFF_LENGTH-1
//  DATA_ADDR_WIDTH  19      width of dataAddr; must hold DATA_LENGTH-1
//  FILTER_LATENCY   3       cycles from filterEnable to the matching filter output (>=1)
//  OUT_COUNT_WIDTH  19      width of outputCount; must hold DATA_LENGTH+COEFF_LENGTH-1
// PORTS
//  clock         in   1                 system clock; all logic on posedge
//  reset         in   1                 synchronous, active-high reset
//  enable        in   1                 level; high starts a run from IDLE; low mid-run aborts
//  coeffAddr     out  COEFF_ADDR_WIDTH  coefficient ROM address
//  coeffLoad     out  1                 coefficient write strobe into the filter
//  sampleValid   in   1                 source presents a sample this cycle
//  sampleReady   out  1                 controller accepts a sample this cycle
//  dataAddr      out  DATA_ADDR_WIDTH   index of the next sample to accept
//  filterEnable  out  1                 advance the filter by one sample
//  zeroInput     out  1                 filter input forced to 0 (flush)
//  mfOutputValid out  1                 filter output (MFOutputRe/Im) is valid this cycle
//  outputCount   out  OUT_COUNT_WIDTH   number of valid outputs flagged in this run
//  busy          out  1                 high in every state except IDLE and DONE
//  done          out  1                 run complete; held high in DONE
// BEHAVIOUR
//  - State and counters are registered. All outputs except mfOutputValid and outputCount are a combinational
//    decode of state/counters and the inputs. reset forces IDLE, clears all counters and the valid pipeline,
//    and drives every output to 0 on the next edge.
//  - IDLE: all outputs 0. If enable=1: next state LOAD_COEFF; coeffAddr, dataAddr, outputCount and the
//    flush counter are cleared.
//  - LOAD_COEFF: coeffLoad=1 every cycle. coeffAddr steps 0..COEFF_LENGTH-1, one per cycle. After the cycle
//    with addr=COEFF_LENGTH-1 the next state is STREAM. ROM read latency is absorbed by the filter, not here.
//  - STREAM: sampleReady=1. Accept = sampleValid & sampleReady, and filterEnable=accept. dataAddr increments
//    on each accept. An accept with dataAddr=DATA_LENGTH-1 moves to FLUSH. Cycles without sampleValid stall
//    with no penalty.
//  - FLUSH: sampleReady=0, zeroInput=1, filterEnable=1 for exactly COEFF_LENGTH-1 cycles, then DRAIN.
//  - DRAIN: filterEnable=0. Stays here until the valid pipeline is empty, then DONE.
//  - DONE: done=1, busy=0. Holds until enable=0, then IDLE. No restart while enable stays high.
//  - Valid pipeline: a FILTER_LATENCY-deep shift register of filterEnable whose output is mfOutputValid.
//    outputCount increments on each mfOutputValid. A full run flags exactly DATA_LENGTH+COEFF_LENGTH-1 outputs.
//  - Abort: enable=0 in LOAD_COEFF, STREAM, FLUSH or DRAIN moves to IDLE on the next edge. The valid pipeline
//    and counters are cleared, and no done is issued.
//  - Counters never wrap; terminal values are compared exactly.
//  - reset has priority over enable in the same cycle.
// TESTING  (COEFF_LENGTH=4, DATA_LENGTH=8, FILTER_LATENCY=3)
//  1. reset held 3 cycles, enable=1 -> all outputs 0 while in reset; state stays IDLE until reset falls.
//  2. enable rises at cycle 0 -> coeffLoad=1 in cycles 1-4 with coeffAddr 0,1,2,3; sampleReady=1 from cycle 5.
//  3. sampleValid held 1 -> filterEnable cycles 5-12 (dataAddr 0..7), zeroInput cycles 13-15,
//     mfOutputValid cycles 8-18, outputCount=11, done=1 from cycle 19.
//  4. sampleValid pattern 1,0,1,0... -> filterEnable only on valid cycles; 8 accepts total;
//     dataAddr holds on stall cycles; outputCount still ends at 11.
//  5. enable dropped after the 3rd accept -> IDLE next edge; sampleReady=0; mfOutputValid=0; done stays 0.
//  6. reset pulsed during FLUSH -> next edge: all outputs 0, outputCount=0; a new enable gives a clean full run.

Source files
------------

// File: rtl/matched_filter_controller.sv
// Run sequencer for the matched filter: coefficient load, sample stream, zero flush, drain, done.
// Sample accept is combinational on sampleValid (no penalty on stalls); mfOutputValid trails filterEnable by FILTER_LATENCY.
module matched_filter_controller #(
  parameter int COEFF_LENGTH     = 10000,
  parameter int DATA_LENGTH      = 330000,
  parameter int COEFF_ADDR_WIDTH = 14,
  parameter int DATA_ADDR_WIDTH  = 19,
  parameter int FILTER_LATENCY   = 3,
  parameter int OUT_COUNT_WIDTH  = 19
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  output logic [COEFF_ADDR_WIDTH-1:0] coeffAddr,
  output logic                        coeffLoad,
  input  logic                        sampleValid,
  output logic                        sampleReady,
  output logic [DATA_ADDR_WIDTH-1:0]  dataAddr,
  output logic                        filterEnable,
  output logic                        zeroInput,
  output logic                        mfOutputValid,
  output logic [OUT_COUNT_WIDTH-1:0]  outputCount,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {IDLE, LOAD_COEFF, STREAM, FLUSH, DRAIN, DONE} state_t;

  localparam logic [COEFF_ADDR_WIDTH-1:0] COEFF_LAST = COEFF_ADDR_WIDTH'(COEFF_LENGTH - 1);
  localparam logic [COEFF_ADDR_WIDTH-1:0] FLUSH_LAST = COEFF_ADDR_WIDTH'(COEFF_LENGTH - 2);
  localparam logic [DATA_ADDR_WIDTH-1:0]  DATA_LAST  = DATA_ADDR_WIDTH'(DATA_LENGTH - 1);
  localparam logic [FILTER_LATENCY-1:0]   PIPE_MSB   = FILTER_LATENCY'(1) << (FILTER_LATENCY - 1);

  state_t                        state, state_nxt;
  logic [COEFF_ADDR_WIDTH-1:0]   coeff_cnt, flush_cnt;
  logic [DATA_ADDR_WIDTH-1:0]    data_cnt;
  logic [OUT_COUNT_WIDTH-1:0]    out_cnt;
  logic [FILTER_LATENCY-1:0]     vld_pipe;
  logic                          accept;

  assign coeffAddr     = coeff_cnt;
  assign dataAddr      = data_cnt;
  assign outputCount   = out_cnt;
  assign mfOutputValid = vld_pipe[FILTER_LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    coeffLoad    = 1'b0;
    sampleReady  = 1'b0;
    accept       = 1'b0;
    filterEnable = 1'b0;
    zeroInput    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LOAD_COEFF;
      end
      LOAD_COEFF: begin
        busy      = 1'b1;
        coeffLoad = 1'b1;
        if (!enable)                 state_nxt = IDLE;
        else if (coeff_cnt == COEFF_LAST) state_nxt = STREAM;
      end
      STREAM: begin
        busy         = 1'b1;
        sampleReady  = 1'b1;
        accept       = sampleValid;
        filterEnable = accept;
        if (!enable)                              state_nxt = IDLE;
        else if (accept && data_cnt == DATA_LAST) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy         = 1'b1;
        zeroInput    = 1'b1;
        filterEnable = 1'b1;
        if (!enable)                      state_nxt = IDLE;
        else if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once the only remaining in-flight bit is the one emerging this cycle.
        if (!enable)                           state_nxt = IDLE;
        else if ((vld_pipe & ~PIPE_MSB) == '0) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every entry into IDLE (reset, abort, end of run) leaves counters and pipeline clean.
  always_ff @(posedge clock) begin
    if (reset || state_nxt == IDLE) begin
      coeff_cnt <= '0;
      flush_cnt <= '0;
      data_cnt  <= '0;
      out_cnt   <= '0;
      vld_pipe  <= '0;
    end else begin
      if (state == LOAD_COEFF && coeff_cnt != COEFF_LAST) coeff_cnt <= coeff_cnt + 1'b1;
      if (state == FLUSH && flush_cnt != FLUSH_LAST)      flush_cnt <= flush_cnt + 1'b1;
      if (accept && data_cnt != DATA_LAST)                data_cnt  <= data_cnt + 1'b1;
      if (mfOutputValid)                                  out_cnt   <= out_cnt + 1'b1;
      vld_pipe <= FILTER_LATENCY'({vld_pipe, filterEnable});
    end
  end

endmodule

// File: tb/tb_matched_filter_controller.sv
// Directed bench for matched_filter_controller with a 4-tap, 8-sample, latency-3 configuration.
module tb_matched_filter_controller;
  localparam int CL  = 4;
  localparam int DL  = 8;
  localparam int FL  = 3;
  localparam int CAW = 2;
  localparam int DAW = 3;
  localparam int OCW = 4;

  logic           clock;
  logic           reset;
  logic           enable;
  logic [CAW-1:0] coeffAddr;
  logic           coeffLoad;
  logic           sampleValid;
  logic           sampleReady;
  logic [DAW-1:0] dataAddr;
  logic           filterEnable;
  logic           zeroInput;
  logic           mfOutputValid;
  logic [OCW-1:0] outputCount;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;

  matched_filter_controller #(
    .COEFF_LENGTH(CL), .DATA_LENGTH(DL), .COEFF_ADDR_WIDTH(CAW),
    .DATA_ADDR_WIDTH(DAW), .FILTER_LATENCY(FL), .OUT_COUNT_WIDTH(OCW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .coeffAddr(coeffAddr), .coeffLoad(coeffLoad),
    .sampleValid(sampleValid), .sampleReady(sampleReady), .dataAddr(dataAddr),
    .filterEnable(filterEnable), .zeroInput(zeroInput),
    .mfOutputValid(mfOutputValid), .outputCount(outputCount),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Flag order: coeffLoad sampleReady filterEnable zeroInput mfOutputValid busy done
  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; sampleValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done} !== 7'b0
          || outputCount !== '0 || coeffAddr !== '0 || dataAddr !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d flags=%b cnt=%0d caddr=%0d daddr=%0d required all zero",
                 i, {coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done},
                 outputCount, coeffAddr, dataAddr);
      end
    end
    reset = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || coeffLoad !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b coeffLoad=%b required 0 0", busy, coeffLoad);
    end
    tick();
    checks++;
    if (coeffLoad !== 1'b1 || coeffAddr !== 2'd0) begin
      failures++;
      $display("FAIL reset_release coeffLoad=%b coeffAddr=%0d required 1 0", coeffLoad, coeffAddr);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || coeffAddr !== 2'd0) begin
      failures++;
      $display("FAIL reset_abort_load busy=%b coeffAddr=%0d required 0 0", busy, coeffAddr);
    end
  endtask

  task automatic test_full_run;
    logic [6:0] exp_f, obs_f;
    reset = 1'b0; enable = 1'b1; sampleValid = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      #2;
      exp_f = {c >= 1 && c <= 4, c >= 5 && c <= 12, c >= 5 && c <= 15, c >= 13 && c <= 15,
               c >= 8 && c <= 18, c >= 1 && c <= 18, c >= 19};
      obs_f = {coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done};
      checks++;
      if (obs_f !== exp_f) begin
        failures++;
        $display("FAIL full_run_flags cyc=%0d got=%b required=%b", c, obs_f, exp_f);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (coeffAddr !== CAW'(c - 1)) begin
          failures++;
          $display("FAIL full_run_coeffAddr cyc=%0d got=%0d required=%0d", c, coeffAddr, c - 1);
        end
      end
      if (c >= 5 && c <= 12) begin
        checks++;
        if (dataAddr !== DAW'(c - 5)) begin
          failures++;
          $display("FAIL full_run_dataAddr cyc=%0d got=%0d required=%0d", c, dataAddr, c - 5);
        end
      end
      if (c >= 19) begin
        checks++;
        if (outputCount !== OCW'(11)) begin
          failures++;
          $display("FAIL full_run_outputCount cyc=%0d got=%0d required=11", c, outputCount);
        end
      end
      tick();
    end
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || outputCount !== '0 || dataAddr !== '0) begin
      failures++;
      $display("FAIL full_run_back_to_idle busy=%b done=%b cnt=%0d daddr=%0d required 0 0 0 0",
               busy, done, outputCount, dataAddr);
    end
  endtask

  task automatic test_stall;
    logic       fe_hist [0:31];
    logic [3:0] exp_f, obs_f;
    logic       fe_exp, mf_exp;
    int acc    = 0;
    int fe_cnt = 0;
    enable = 1'b1;
    for (int c = 0; c <= 27; c++) begin
      sampleValid = (c >= 5) && ((c - 5) % 2 == 0);
      #2;
      fe_exp = ((c >= 5 && c <= 19) && sampleValid) || (c >= 20 && c <= 22);
      fe_hist[c] = fe_exp;
      mf_exp = (c >= 3) ? fe_hist[c - 3] : 1'b0;
      exp_f = {fe_exp, c >= 20 && c <= 22, mf_exp, c >= 26};
      obs_f = {filterEnable, zeroInput, mfOutputValid, done};
      checks++;
      if (obs_f !== exp_f) begin
        failures++;
        $display("FAIL stall_flags cyc=%0d fe/zero/mfv/done got=%b required=%b", c, obs_f, exp_f);
      end
      if (c >= 5 && c <= 19) begin
        checks++;
        if (dataAddr !== DAW'(acc)) begin
          failures++;
          $display("FAIL stall_dataAddr cyc=%0d got=%0d required=%0d", c, dataAddr, acc);
        end
        if (sampleValid) acc++;
        if (filterEnable === 1'b1) fe_cnt++;
      end
      if (c == 26) begin
        checks++;
        if (outputCount !== OCW'(11)) begin
          failures++;
          $display("FAIL stall_outputCount got=%0d required=11", outputCount);
        end
      end
      tick();
    end
    checks++;
    if (fe_cnt != DL) begin
      failures++;
      $display("FAIL stall_accepts got=%0d required=%0d", fe_cnt, DL);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    enable = 1'b1; sampleValid = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    enable = 1'b0; sampleValid = 1'b0;
    #2;
    checks++;
    if (mfOutputValid !== 1'b1 || busy !== 1'b1 || dataAddr !== 3'd3) begin
      failures++;
      $display("FAIL abort_before mfv=%b busy=%b daddr=%0d required 1 1 3",
               mfOutputValid, busy, dataAddr);
    end
    for (int c = 9; c <= 12; c++) begin
      tick();
      checks++;
      if ({coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done} !== 7'b0
          || outputCount !== '0 || dataAddr !== '0) begin
        failures++;
        $display("FAIL abort_after cyc=%0d flags=%b cnt=%0d daddr=%0d required all zero",
                 c, {coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done},
                 outputCount, dataAddr);
      end
    end
  endtask

  task automatic test_reset_flush;
    enable = 1'b1; sampleValid = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    #2;
    checks++;
    if (zeroInput !== 1'b1 || outputCount !== 4'd6) begin
      failures++;
      $display("FAIL flush_before_reset zero=%b cnt=%0d required 1 6", zeroInput, outputCount);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done} !== 7'b0
        || outputCount !== '0) begin
      failures++;
      $display("FAIL flush_reset flags=%b cnt=%0d required all zero",
               {coeffLoad, sampleReady, filterEnable, zeroInput, mfOutputValid, busy, done},
               outputCount);
    end
    test_full_run();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sampleValid = 1'b0;
    test_reset();
    test_full_run();
    test_stall();
    test_abort();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
